alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 16-bit combinational ALU. Adds variable-distance
//  shifts/rotates and an iterative shift-add multiply. Registers results and flags behind
//  valid/ready on both sides, so it drops into the datapath as a multi-cycle execute unit.
//  Accepts one operation at a time.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 4 and a power of 2
//  SHW    4   shift-amount width = log2(WIDTH); b[SHW-1:0] is the shift distance
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      op/a/b/cin valid
//  in_ready   out  1      unit can accept (high only in IDLE)
//  op         in   5      opcode, see BEHAVIOUR
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B / shift distance
//  cin        in   1      external carry-in (ADC, SBC)
//  out_valid  out  1      y/flags/err valid
//  out_ready  in   1      consumer accepts result
//  y          out  WIDTH  result
//  z,n,c,v    out  1 ea   zero, negative, carry, overflow flags
//  err        out  1      unknown opcode
// BEHAVIOUR
//  Opcodes:
//   00 ADD  a+b          01 ADC  a+b+cin      02 SUB  a-b          03 SBC  a-b-!cin
//   04 AND               05 OR                06 XOR               07 NOT  ~a
//   08 LSR  a>>s         09 LSL  a<<s         0A ASR  a>>>s        0B ROR  rotate-right by s
//   0C MUL  low WIDTH bits of a*b (unsigned)  0D CMP  as SUB, but y is not updated
//   Other codes: y=0, z=1, n=c=v=0, err=1.
//   s = b[SHW-1:0].
//  Reset: state=IDLE; in_ready=1; out_valid=0; y=0; z=n=c=v=0; err=0. Async assert, sync deassert.
//  FSM: IDLE -> EXEC on in_valid&&in_ready (operands latched). EXEC -> DONE when the op
//   completes. DONE -> IDLE on out_ready. out_valid is high only in DONE, where y/flags are stable.
//  Latency (accept edge to out_valid high):
//   ops 00-07, 0D and illegal: 1 cycle.
//   shifts/rotate: max(s,1) cycles; one bit position per EXEC cycle; s=0 returns a unchanged.
//   MUL: WIDTH cycles; one multiplier bit per cycle, LSB first.
//  Throughput: next accept is no earlier than the cycle after the DONE->IDLE handshake.
//   in_ready=0 in EXEC and DONE.
//  Flags, computed on the final result:
//   z = (y==0); n = y[WIDTH-1].
//   ADD/ADC: c = carry out of the WIDTH-bit add; v = signed overflow.
//   SUB/SBC/CMP: c = NOT borrow (1 when a >= b + borrow-in, unsigned); v = signed overflow.
//   Logic ops: c=0, v=0.
//   LSR/LSL/ASR/ROR: c = last bit shifted out (ROR: bit rotated into the MSB); s=0 -> c=0; v=0.
//   MUL: c = 1 if the upper WIDTH bits of the full product are nonzero; v=0.
//   CMP: y keeps its previous value; z/n are taken from the internal difference.
//  Boundaries:
//   in_valid while busy: ignored; the upstream must hold it.
//   out_ready already high on entering DONE: out_valid pulses for exactly 1 cycle.
//   rst_n asserted mid-EXEC or DONE: the operation is aborted and no result is emitted.
//   Operands changing after acceptance have no effect.
// TESTING
//  ADD a=7FFF b=0001 -> y=8000 n=1 v=1 c=0 z=0, out_valid 1 cycle after accept.
//  SUB a=0005 b=0005; then SBC a=0000 b=0000 cin=0 -> y=0000 z=1 c=1; then y=FFFF n=1 c=0.
//  LSR a=9001 b=0004 -> y=0900 c=0, out_valid 4 cycles after accept;
//   ROR a=0001 b=0001 -> y=8000 c=1.
//  MUL a=0100 b=0100 -> y=0000 z=1 c=1 after 16 cycles;
//   MUL a=00FF b=0003 -> y=02FD c=0.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE -> y/flags stable, in_ready=0,
//   second in_valid not accepted.
//  Reset mid-MUL at cycle 8 -> out_valid=0, y=0, flags 0, in_ready=1; op=1F -> err=1 y=0 z=1.

Source files
------------

// File: rtl/alu_seq.sv
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked multi-cycle ALU with bit-serial shifts/rotate and an
//             iterative shift-add multiplier.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             err
);

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_ADC = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_SBC = 5'h03;
    localparam logic [4:0] OP_AND = 5'h04;
    localparam logic [4:0] OP_OR  = 5'h05;
    localparam logic [4:0] OP_XOR = 5'h06;
    localparam logic [4:0] OP_NOT = 5'h07;
    localparam logic [4:0] OP_LSR = 5'h08;
    localparam logic [4:0] OP_LSL = 5'h09;
    localparam logic [4:0] OP_ASR = 5'h0A;
    localparam logic [4:0] OP_ROR = 5'h0B;
    localparam logic [4:0] OP_MUL = 5'h0C;
    localparam logic [4:0] OP_CMP = 5'h0D;

    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [4:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               cin_r;
    logic [SHW:0]       cnt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;

    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH:0]     sum;
    logic               ovf;
    logic [WIDTH-1:0]   sh_nxt;
    logic               sh_out;
    logic               is_shift;
    logic [2*WIDTH-1:0] prod_nxt;

    logic               done_now;
    logic               upd_y;
    logic [WIDTH-1:0]   res_y;
    logic               res_c;
    logic               res_v;
    logic               res_err;

    // Subtraction is a + ~b + carry-in, so the carry out is directly NOT borrow.
    always_comb begin
        add_b   = b_r;
        add_cin = 1'b0;
        case (op_r)
            OP_ADC:         add_cin = cin_r;
            OP_SUB, OP_CMP: begin add_b = ~b_r; add_cin = 1'b1;  end
            OP_SBC:         begin add_b = ~b_r; add_cin = cin_r; end
            default:        ;
        endcase
        sum = {1'b0, a_r} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        ovf = (a_r[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
    end

    always_comb begin
        sh_nxt   = a_r;
        sh_out   = 1'b0;
        is_shift = 1'b1;
        case (op_r)
            OP_LSR:  begin sh_nxt = {1'b0, a_r[WIDTH-1:1]};          sh_out = a_r[0];       end
            OP_LSL:  begin sh_nxt = {a_r[WIDTH-2:0], 1'b0};          sh_out = a_r[WIDTH-1]; end
            OP_ASR:  begin sh_nxt = {a_r[WIDTH-1], a_r[WIDTH-1:1]};  sh_out = a_r[0];       end
            OP_ROR:  begin sh_nxt = {a_r[0], a_r[WIDTH-1:1]};        sh_out = a_r[0];       end
            default: is_shift = 1'b0;
        endcase
        prod_nxt = prod + (b_r[0] ? mcand : {2*WIDTH{1'b0}});
    end

    always_comb begin
        done_now = 1'b0;
        upd_y    = 1'b1;
        res_y    = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        res_err  = 1'b0;
        case (op_r)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                done_now = 1'b1;
                upd_y    = (op_r != OP_CMP);
                res_y    = sum[WIDTH-1:0];
                res_c    = sum[WIDTH];
                res_v    = ovf;
            end
            OP_AND: begin done_now = 1'b1; res_y = a_r & b_r; end
            OP_OR:  begin done_now = 1'b1; res_y = a_r | b_r; end
            OP_XOR: begin done_now = 1'b1; res_y = a_r ^ b_r; end
            OP_NOT: begin done_now = 1'b1; res_y = ~a_r;      end
            OP_LSR, OP_LSL, OP_ASR, OP_ROR: begin
                if (cnt == '0) begin
                    done_now = 1'b1;
                    res_y    = a_r;
                end else begin
                    done_now = (cnt == CNT_ONE);
                    res_y    = sh_nxt;
                    res_c    = sh_out;
                end
            end
            OP_MUL: begin
                done_now = (cnt == CNT_ONE);
                res_y    = prod_nxt[WIDTH-1:0];
                res_c    = |prod_nxt[2*WIDTH-1:WIDTH];
            end
            default: begin
                done_now = 1'b1;
                res_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            z         <= 1'b0;
            n         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
            err       <= 1'b0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cin_r     <= 1'b0;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        a_r      <= a;
                        b_r      <= b;
                        cin_r    <= cin;
                        cnt      <= (op == OP_MUL) ? CNT_MUL : {1'b0, b[SHW-1:0]};
                        prod     <= '0;
                        mcand    <= {{WIDTH{1'b0}}, a};
                        in_ready <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_shift && cnt != '0) begin
                        a_r <= sh_nxt;
                        cnt <= cnt - CNT_ONE;
                    end
                    if (op_r == OP_MUL) begin
                        prod  <= prod_nxt;
                        mcand <= mcand << 1;
                        b_r   <= b_r >> 1;
                        cnt   <= cnt - CNT_ONE;
                    end
                    if (done_now) begin
                        if (upd_y)
                            y <= res_y;
                        z         <= (res_y == '0);
                        n         <= res_y[WIDTH-1];
                        c         <= res_c;
                        v         <= res_v;
                        err       <= res_err;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed self-checking bench for alu_seq.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y;
    logic        z, n, c, v, err;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    alu_seq #(.WIDTH(16), .SHW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .z(z), .n(n), .c(c), .v(v), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble operands after acceptance, wait for out_valid.
    task automatic run_op(input logic [4:0] o, input logic [15:0] ia, input logic [15:0] ib,
                          input logic ic, output int l);
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        op = o; a = ia; b = ib; cin = ic; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 5'h00; a = 16'hDEAD; b = 16'hBEEF; cin = ~ic;
        l = 0;
        do begin
            @(posedge clk); #1;
            l++;
        end while (!out_valid && l < 40);
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [15:0] ey, input logic [4:0] ef,
                             input int elat, input int l);
        check({tag, "_y"}, {16'd0, y}, {16'd0, ey});
        check({tag, "_znvce"}, {27'd0, z, n, c, v, err}, {27'd0, ef});
        check({tag, "_lat"}, l, elat);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_out_valid_low", {31'd0, out_valid}, 32'd0);
    endtask

    // Flag vector order: {z, n, c, v, err}
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {16'd0, y}, 32'd0);
        check("rst_flags", {27'd0, z, n, c, v, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(5'h00, 16'h7FFF, 16'h0001, 1'b0, lat); check_res("add_ovf", 16'h8000, 5'b01010, 1, lat); handshake();
        run_op(5'h02, 16'h0005, 16'h0005, 1'b0, lat); check_res("sub_eq",  16'h0000, 5'b10100, 1, lat); handshake();
        run_op(5'h03, 16'h0000, 16'h0000, 1'b0, lat); check_res("sbc_brw", 16'hFFFF, 5'b01000, 1, lat); handshake();
        run_op(5'h01, 16'h8000, 16'h8000, 1'b1, lat); check_res("adc_c",   16'h0001, 5'b00110, 1, lat); handshake();
        run_op(5'h04, 16'hF0F0, 16'h3C3C, 1'b0, lat); check_res("and",     16'h3030, 5'b00000, 1, lat); handshake();
        run_op(5'h05, 16'hF0F0, 16'h3C3C, 1'b0, lat); check_res("or",      16'hFCFC, 5'b01000, 1, lat); handshake();
        run_op(5'h06, 16'hF0F0, 16'h3C3C, 1'b0, lat); check_res("xor",     16'hCCCC, 5'b01000, 1, lat); handshake();
        run_op(5'h07, 16'h00FF, 16'h0000, 1'b0, lat); check_res("not",     16'hFF00, 5'b01000, 1, lat); handshake();
        // CMP leaves y at FF00 from NOT; z/n/c from 3-5
        run_op(5'h0D, 16'h0003, 16'h0005, 1'b0, lat); check_res("cmp_lt",  16'hFF00, 5'b01000, 1, lat); handshake();
        run_op(5'h08, 16'h9001, 16'h0004, 1'b0, lat); check_res("lsr4",    16'h0900, 5'b00000, 4, lat); handshake();
        run_op(5'h0B, 16'h0001, 16'h0001, 1'b0, lat); check_res("ror1",    16'h8000, 5'b01100, 1, lat); handshake();
        run_op(5'h09, 16'h8001, 16'h0000, 1'b0, lat); check_res("lsl0",    16'h8001, 5'b01000, 1, lat); handshake();
        run_op(5'h0A, 16'h8000, 16'h0013, 1'b0, lat); check_res("asr3",    16'hF000, 5'b01000, 3, lat); handshake();
        run_op(5'h09, 16'h0003, 16'h000F, 1'b0, lat); check_res("lsl15",   16'h8000, 5'b01100, 15, lat); handshake();
        run_op(5'h0C, 16'h0100, 16'h0100, 1'b0, lat); check_res("mul_hi",  16'h0000, 5'b10100, 16, lat); handshake();
        run_op(5'h0C, 16'h00FF, 16'h0003, 1'b0, lat); check_res("mul_lo",  16'h02FD, 5'b00000, 16, lat); handshake();
        run_op(5'h0E, 16'h1234, 16'h5678, 1'b0, lat); check_res("illegal", 16'h0000, 5'b10001, 1, lat); handshake();

        // Backpressure: result held, second request ignored while busy
        run_op(5'h00, 16'h0001, 16'h0002, 1'b0, lat); check_res("bp_add", 16'h0003, 5'b00000, 1, lat);
        op = 5'h07; a = 16'h0000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_y", {16'd0, y}, 32'h0003);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        handshake();
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk); #1;
        check("bp_no_second", {31'd0, out_valid}, 32'd0);
        check("bp_y_kept", {16'd0, y}, 32'h0003);

        // out_ready already high: single-cycle out_valid pulse
        out_ready = 1'b1;
        run_op(5'h06, 16'h00FF, 16'h0F0F, 1'b0, lat); check_res("pulse_xor", 16'h0FF0, 5'b00000, 1, lat);
        @(posedge clk); #1;
        check("pulse_low", {31'd0, out_valid}, 32'd0);
        check("pulse_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Reset mid-MUL aborts the operation
        op = 5'h0C; a = 16'h00FF; b = 16'h0003; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_y", {16'd0, y}, 32'd0);
        check("rstmid_flags", {27'd0, z, n, c, v, err}, 32'd0);
        check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rstmid_no_result", {31'd0, out_valid}, 32'd0);
        run_op(5'h1F, 16'hFFFF, 16'hFFFF, 1'b1, lat); check_res("op1f", 16'h0000, 5'b10001, 1, lat); handshake();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
